// File: rtl/manchester_frame_sched.sv
// Frame scheduler sharing one Manchester encoder between two byte streams.
// Each frame is sent as preamble, SFD, payload, then an inter-frame gap, one byte per 2-cycle slot.
module manchester_frame_sched #(
    parameter int unsigned PRE_LEN   = 2,
    parameter logic [7:0]  PRE_BYTE  = 8'hAA,
    parameter logic [7:0]  SFD_BYTE  = 8'hD5,
    parameter logic [7:0]  IDLE_BYTE = 8'hAA,
    parameter int unsigned IFG_LEN   = 3
) (
    input  logic       pclk,
    input  logic       aresetn,
    input  logic       en,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    input  logic       s0_tlast,
    output logic       s0_tready,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    input  logic       s1_tlast,
    output logic       s1_tready,
    output logic [7:0] tx_data,
    output logic       tx_half,
    output logic       tx_active,
    output logic [1:0] grant,
    output logic       underrun
);
    localparam int unsigned CMAX = (PRE_LEN > IFG_LEN) ? PRE_LEN : IFG_LEN;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_LEN - 1);

    typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, IFG} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            rr, rr_nx;          // 1 = contention goes to s1
    logic            last_ld, last_nx;   // final payload beat is on tx_data
    logic [7:0]      data_nx;
    logic            active_nx, und_nx, pick1;
    logic [1:0]      grant_nx;

    logic [1:0]      req_valid, req_last, tready;
    logic [1:0][7:0] req_data;
    logic            take, g_valid, g_last;
    logic [7:0]      g_data;

    assign req_valid = {s1_tvalid, s0_tvalid};
    assign req_last  = {s1_tlast, s0_tlast};
    assign req_data  = {s1_tdata, s0_tdata};

    // A beat is only taken on the boundary cycle of an SFD/PAY slot, and never once tlast is loaded.
    assign take = (state == SFD || state == PAY) && !last_ld && tx_half;

    for (genvar i = 0; i < 2; i++) begin : g_rdy
        assign tready[i] = take & grant[i] & req_valid[i];
    end

    assign s0_tready = tready[0];
    assign s1_tready = tready[1];

    assign g_valid = |(req_valid & grant);
    assign g_last  = grant[1] ? req_last[1] : req_last[0];
    assign g_data  = grant[1] ? req_data[1] : req_data[0];

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rr_nx     = rr;
        last_nx   = last_ld;
        data_nx   = tx_data;
        active_nx = tx_active;
        grant_nx  = grant;
        und_nx    = 1'b0;
        pick1     = req_valid[1] & (~req_valid[0] | rr);
        if (tx_half) begin
            case (state)
                IDLE: begin
                    if (en && |req_valid) begin
                        if (&req_valid) rr_nx = ~rr;
                        grant_nx  = pick1 ? 2'b10 : 2'b01;
                        active_nx = 1'b1;
                        data_nx   = PRE_BYTE;
                        cnt_nx    = '0;
                        state_nx  = PRE;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        cnt_nx   = '0;
                        data_nx  = SFD_BYTE;
                        state_nx = SFD;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                SFD, PAY: begin
                    if (last_ld || !g_valid) begin
                        // Normal end of frame, or abort because the owner ran dry.
                        und_nx    = ~last_ld;
                        last_nx   = 1'b0;
                        cnt_nx    = '0;
                        data_nx   = IDLE_BYTE;
                        active_nx = 1'b0;
                        grant_nx  = 2'b00;
                        state_nx  = IFG;
                    end else begin
                        data_nx  = g_data;
                        last_nx  = g_last;
                        state_nx = PAY;
                    end
                end
                IFG: begin
                    if (cnt == IFG_LAST) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rr        <= 1'b0;
            last_ld   <= 1'b0;
            tx_data   <= IDLE_BYTE;
            tx_half   <= 1'b0;
            tx_active <= 1'b0;
            grant     <= 2'b00;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rr        <= rr_nx;
            last_ld   <= last_nx;
            tx_data   <= data_nx;
            tx_half   <= ~tx_half;
            tx_active <= active_nx;
            grant     <= grant_nx;
            underrun  <= und_nx;
        end
    end
endmodule

// File: tb/tb_manchester_frame_sched.sv
// Bench for manchester_frame_sched: slot streams are compared against a frame-level model
// built from the queued payload, plus directed reset, contention, underrun and enable sequences.
`timescale 1ns/1ps
module tb_manchester_frame_sched;
    localparam int PRE_LEN = 2;
    localparam int IFG_LEN = 3;
    localparam logic [7:0] PRE_B  = 8'hAA;
    localparam logic [7:0] SFD_B  = 8'hD5;
    localparam logic [7:0] IDLE_B = 8'hAA;

    logic       pclk = 1'b0, aresetn = 1'b0, en = 1'b1;
    logic [7:0] s0_tdata = 8'h00, s1_tdata = 8'h00;
    logic       s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
    logic       s0_tready, s1_tready, tx_half, tx_active, underrun;
    logic [7:0] tx_data;
    logic [1:0] grant;

    manchester_frame_sched dut (
        .pclk(pclk), .aresetn(aresetn), .en(en),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .tx_data(tx_data), .tx_half(tx_half), .tx_active(tx_active), .grant(grant),
        .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {logic [7:0] d; logic l;} beat_t;
    typedef struct packed {logic [7:0] d; logic a; logic [1:0] g; logic u;} slot_t;
    typedef struct {
        int req; int len; bit trunc; logic [7:0] base;
        int exp_act; int exp_und; int exp_hs; logic [1:0] exp_g;
    } vec_t;

    beat_t q0[$], q1[$];
    slot_t got[$], ex[$];
    bit    mon_en = 1'b0;
    int    hs0, hs1, bad_rdy, hold_err;
    int    checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, req);
        end
    endtask

    // Requester drivers: present the queue head, pop it after a handshake.
    initial begin : drv
        bit p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        forever begin
            @(negedge pclk);
            if (p0 && q0.size() > 0) q0.delete(0);
            if (p1 && q1.size() > 0) q1.delete(0);
            s0_tvalid = q0.size() > 0;
            if (q0.size() > 0) begin s0_tdata = q0[0].d; s0_tlast = q0[0].l; end
            s1_tvalid = q1.size() > 0;
            if (q1.size() > 0) begin s1_tdata = q1[0].d; s1_tlast = q1[0].l; end
            #1;
            p0 = s0_tready; p1 = s1_tready;
            if (s0_tready) hs0++;
            if (s1_tready) hs1++;
            if ((s0_tready && !grant[0]) || (s1_tready && !grant[1])) bad_rdy++;
        end
    end

    // Slot monitor: record the first half of every slot, check the second half holds.
    initial begin : mon
        forever begin
            @(negedge pclk);
            if (mon_en) begin
                if (!tx_half) got.push_back({tx_data, tx_active, grant, underrun});
                else if (got.size() > 0 && (tx_data !== got[$].d || tx_active !== got[$].a ||
                         grant !== got[$].g || underrun !== 1'b0)) hold_err++;
            end
        end
    end

    task automatic begin_reset();
        @(posedge pclk); #1;
        aresetn = 1'b0; mon_en = 1'b0;
        q0.delete(); q1.delete(); got.delete();
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge pclk);
        #1;
        hs0 = 0; hs1 = 0; bad_rdy = 0; hold_err = 0;
        aresetn = 1'b1; mon_en = 1'b1;
    endtask

    task automatic load_frame(input int req, input int len, input bit trunc, input logic [7:0] base,
                              input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? 8'($urandom) : base + 8'(i) * 8'h11;
            b.l = (i == len - 1) && !trunc;
            if (req == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    // Frame-level model: walk the queued frames, arbitrate round-robin on contention,
    // and lay out preamble/SFD/payload/gap slots.
    task automatic build_exp();
        beat_t a[$], b[$], bt;
        bit fav1, p1, trunc;
        logic [1:0] g;
        a = q0; b = q1; fav1 = 1'b0;
        ex.delete();
        ex.push_back({IDLE_B, 1'b0, 2'b00, 1'b0});
        while (a.size() > 0 || b.size() > 0) begin
            if (a.size() > 0 && b.size() > 0) begin p1 = fav1; fav1 = !fav1; end
            else p1 = (b.size() > 0);
            g = p1 ? 2'b10 : 2'b01;
            for (int i = 0; i < PRE_LEN; i++) ex.push_back({PRE_B, 1'b1, g, 1'b0});
            ex.push_back({SFD_B, 1'b1, g, 1'b0});
            trunc = 1'b1;
            while (trunc && (p1 ? b.size() : a.size()) > 0) begin
                bt = p1 ? b.pop_front() : a.pop_front();
                ex.push_back({bt.d, 1'b1, g, 1'b0});
                if (bt.l) trunc = 1'b0;
            end
            for (int i = 0; i < IFG_LEN; i++) ex.push_back({IDLE_B, 1'b0, 2'b00, (i == 0) && trunc});
            ex.push_back({IDLE_B, 1'b0, 2'b00, 1'b0});
        end
    endtask

    task automatic run_stream(input string nm);
        int n, cyc;
        slot_t idle_s;
        idle_s = {IDLE_B, 1'b0, 2'b00, 1'b0};
        build_exp();
        release_reset();
        n = ex.size() + 3;
        cyc = 0;
        while (got.size() < n && cyc < 4000) begin @(posedge pclk); cyc++; end
        mon_en = 1'b0;
        if (got.size() < n) begin
            checks++; errors++;
            $display("FAIL %s timeout slots %0d expected %0d", nm, got.size(), n);
        end
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s slot%0d", nm, i), got[i], (i < ex.size()) ? ex[i] : idle_s);
        chk({nm, " hold"}, hold_err, 0);
        chk({nm, " ungranted_rdy"}, bad_rdy, 0);
    endtask

    initial begin
        vec_t vt[5];
        int act, und, cyc, bad, n0, n1, tot0, tot1, min_gap, gap;
        logic [1:0] order[$];

        vt[0] = '{0, 3, 1'b0, 8'h11, 6, 0, 3, 2'b01};
        vt[1] = '{1, 1, 1'b0, 8'h5A, 4, 0, 1, 2'b10};
        vt[2] = '{1, 1, 1'b1, 8'h44, 4, 1, 1, 2'b10};
        vt[3] = '{0, 4, 1'b1, 8'h70, 7, 1, 4, 2'b01};
        vt[4] = '{1, 5, 1'b0, 8'h0F, 8, 0, 5, 2'b10};

        // T1: reset values and tx_half toggle
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_vals", {tx_data, tx_half, tx_active, grant, underrun, s0_tready, s1_tready},
            {IDLE_B, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk($sformatf("half%0d", i), tx_half, i % 2);
        end

        // T2/T4: table of single-requester frames
        for (int k = 0; k < 5; k++) begin
            begin_reset();
            load_frame(vt[k].req, vt[k].len, vt[k].trunc, vt[k].base, 1'b0);
            run_stream($sformatf("vec%0d", k));
            act = 0; und = 0;
            foreach (got[i]) begin act += got[i].a; und += got[i].u; end
            chk($sformatf("vec%0d active_slots", k), act, vt[k].exp_act);
            chk($sformatf("vec%0d underruns", k), und, vt[k].exp_und);
            chk($sformatf("vec%0d treadys", k), (vt[k].req == 0) ? hs0 : hs1, vt[k].exp_hs);
            if (got.size() > 1) chk($sformatf("vec%0d grant", k), got[1].g, vt[k].exp_g);
        end

        // T3: contention order and gap
        begin_reset();
        load_frame(0, 2, 1'b0, 8'h10, 1'b0);
        load_frame(0, 2, 1'b0, 8'h30, 1'b0);
        load_frame(1, 2, 1'b0, 8'h20, 1'b0);
        run_stream("t3");
        order.delete(); min_gap = 1000; gap = 0;
        foreach (got[i]) begin
            if (got[i].a && (i == 0 || !got[i-1].a)) begin
                order.push_back(got[i].g);
                if (order.size() > 1 && gap < min_gap) min_gap = gap;
            end
            gap = got[i].a ? 0 : gap + 1;
        end
        chk("t3 frames", order.size(), 3);
        if (order.size() == 3) begin
            chk("t3 first", order[0], 2'b01);
            chk("t3 second", order[1], 2'b10);
            chk("t3 third", order[2], 2'b01);
        end
        chk("t3 gap_ok", min_gap >= IFG_LEN + 1, 1);

        // Randomized frame mixes against the model
        for (int it = 0; it < 6; it++) begin
            begin_reset();
            n0 = $urandom_range(0, 3); n1 = $urandom_range(0, 3);
            for (int f = 0; f < n0; f++) load_frame(0, $urandom_range(1, 6), 1'b0, 8'h00, 1'b1);
            for (int f = 0; f < n1; f++) load_frame(1, $urandom_range(1, 6), 1'b0, 8'h00, 1'b1);
            tot0 = q0.size(); tot1 = q1.size();
            run_stream($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d hs0", it), hs0, tot0);
            chk($sformatf("rnd%0d hs1", it), hs1, tot1);
        end

        // T5: reset during the second payload slot
        begin_reset();
        load_frame(0, 4, 1'b0, 8'h70, 1'b0);
        release_reset();
        mon_en = 1'b0;
        cyc = 0;
        while (!(tx_active && tx_data == 8'h81) && cyc < 200) begin @(posedge pclk); #1; cyc++; end
        chk("t5 reached_pay2", cyc < 200, 1);
        aresetn = 1'b0;
        #1;
        chk("t5 reset_vals", {tx_data, tx_half, tx_active, grant, underrun, s0_tready, s1_tready},
            {IDLE_B, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        @(posedge pclk); #1;
        aresetn = 1'b1;
        cyc = 0;
        while (!tx_active && cyc < 40) begin @(posedge pclk); #1; cyc++; end
        chk("t5 restart_pre", {tx_active, tx_data}, {1'b1, PRE_B});
        cyc = 0;
        while (!(tx_active && tx_data != PRE_B && tx_data != SFD_B) && cyc < 40) begin
            @(posedge pclk); #1; cyc++;
        end
        chk("t5 restart_pay", tx_data, 8'h92);

        // T6: enable gating
        begin_reset();
        en = 1'b0;
        load_frame(0, 2, 1'b0, 8'hC1, 1'b0);
        load_frame(0, 2, 1'b0, 8'hE3, 1'b0);
        release_reset();
        mon_en = 1'b0;
        bad = 0;
        repeat (30) begin @(posedge pclk); #1; if (tx_active || s0_tready) bad++; end
        chk("t6 en0 quiet", bad, 0);
        chk("t6 en0 hs", hs0, 0);
        en = 1'b1;
        cyc = 0;
        while (!tx_active && cyc < 10) begin @(posedge pclk); #1; cyc++; end
        chk("t6 start", tx_active, 1'b1);
        en = 1'b0;
        cyc = 0;
        while (tx_active && cyc < 40) begin @(posedge pclk); #1; cyc++; end
        chk("t6 frame_done", tx_active, 1'b0);
        chk("t6 frame_hs", hs0, 2);
        bad = 0;
        repeat (40) begin @(posedge pclk); #1; if (tx_active || s0_tready) bad++; end
        chk("t6 held_off", bad, 0);
        en = 1'b1;
        cyc = 0;
        while (!tx_active && cyc < 10) begin @(posedge pclk); #1; cyc++; end
        chk("t6 resume", {tx_active, tx_data}, {1'b1, PRE_B});
        cyc = 0;
        while (tx_active && cyc < 40) begin @(posedge pclk); #1; cyc++; end
        chk("t6 second_hs", hs0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
